axis2wb: RTL and testbench

//  AXI-Stream byte sink with a Wishbone read port: the receive-side counterpart of wb2axis.

---
 rtl/base_pkg.sv | 16 +
 rtl/axis2wb_fifo.sv | 44 ++++
 rtl/axis2wb.sv | 87 ++++++++
 tb/tb_axis2wb.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/base_pkg.sv
// Shared register map and field positions for the stream/Wishbone bridge blocks.
package base_pkg;

  localparam logic AXIS2WB_REG_DATA   = 1'b0;
  localparam logic AXIS2WB_REG_STATUS = 1'b1;

  localparam int AXIS2WB_VALID_BIT = 9;
  localparam int AXIS2WB_LAST_BIT  = 8;
  localparam int AXIS2WB_FULL_BIT  = 16;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } axis2wb_beat_t;

endpackage

// File: rtl/axis2wb_fifo.sv
// Single-clock FIFO of {tlast,tdata} beats; combinational head read, push/pop in the same cycle.
// Only the pointers are reset so the storage array can map onto LUTRAM/BRAM.
module axis2wb_fifo
  import base_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  axis2wb_beat_t i_dat,
  input  logic          i_pop,
  output axis2wb_beat_t o_dat,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  axis2wb_beat_t r_mem [DEPTH];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr[AW-1:0]] <= i_dat;
  end

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_count = r_wr - r_rd;
  assign o_dat   = r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/axis2wb.sv
// AXI-Stream byte sink drained by a two-register Wishbone slave (DATA pops, STATUS peeks).
// Every bus access acks one cycle after stb; o_tready drops only when the FIFO is full.
module axis2wb
  import base_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        o_tready,
  input  logic        i_wb_adr,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack
);

  localparam int AW = $clog2(DEPTH);

  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_count;
  logic [7:0]    w_count8;
  axis2wb_beat_t w_head;
  axis2wb_beat_t w_in;
  logic          w_push;
  logic          w_pop;
  logic          w_access;
  logic [31:0]   w_rdt_nxt;

  logic          r_ack;
  logic [31:0]   r_rdt;

  assign w_in.last = i_tlast;
  assign w_in.data = i_tdata;
  assign w_count8  = 8'(w_count);

  assign o_tready = !w_full && !i_rst;
  assign w_push   = i_tvalid && o_tready;
  assign w_access = i_wb_stb && !r_ack;
  assign w_pop    = w_access && !i_wb_we && (i_wb_adr == AXIS2WB_REG_DATA) && !w_empty;

  axis2wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_dat   (w_in),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_rdt_nxt = '0;
    if (w_access && !i_wb_we) begin
      if (i_wb_adr == AXIS2WB_REG_STATUS) begin
        w_rdt_nxt[AXIS2WB_FULL_BIT] = w_full;
        w_rdt_nxt[7:0]              = w_count8;
      end else if (!w_empty) begin
        w_rdt_nxt[AXIS2WB_VALID_BIT] = 1'b1;
        w_rdt_nxt[AXIS2WB_LAST_BIT]  = w_head.last;
        w_rdt_nxt[7:0]               = w_head.data;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack <= 1'b0;
      r_rdt <= '0;
    end else begin
      r_ack <= w_access;
      r_rdt <= w_rdt_nxt;
    end
  end

  assign o_wb_ack = r_ack;
  assign o_wb_rdt = r_rdt;

endmodule

// File: tb/tb_axis2wb.sv
// Directed bench for axis2wb: reset, FIFO order, full/wrap, concurrent push/pop, writes, mid-stream reset.
module tb_axis2wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tdata = '0;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        wb_adr = 1'b0;
  logic        wb_we = 1'b0;
  logic        wb_stb = 1'b0;
  logic [31:0] wb_rdt;
  logic        wb_ack;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  axis2wb #(.DEPTH(16)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_tdata  (tdata),
    .i_tlast  (tlast),
    .i_tvalid (tvalid),
    .o_tready (tready),
    .i_wb_adr (wb_adr),
    .i_wb_we  (wb_we),
    .i_wb_stb (wb_stb),
    .o_wb_rdt (wb_rdt),
    .o_wb_ack (wb_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bus access: ack must be low as stb rises, high one edge later, low again the edge after.
  task automatic wb_xfer(input logic adr, input logic we, output logic [31:0] rdt, output logic ack_ok);
    logic pre, seen;
    wb_adr = adr;
    wb_we  = we;
    wb_stb = 1'b1;
    pre    = wb_ack;
    step();
    seen   = wb_ack;
    rdt    = wb_rdt;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    step();
    ack_ok = !pre && seen && !wb_ack;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    step();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic ok;
    n_total++;
    if (tready !== 1'b0 || wb_ack !== 1'b0 || wb_rdt !== 32'h0) $display("FAIL reset_hold: tready=%b ack=%b rdt=%h, want 0/0/0", tready, wb_ack, wb_rdt);
    else n_pass++;
    step();
    rst = 1'b0;
    #1;
    n_total++;
    if (tready !== 1'b1) $display("FAIL reset_tready: got %b want 1", tready);
    else n_pass++;
    step();
    wb_xfer(1'b1, 1'b0, r, ok);
    n_total++;
    if (r !== 32'h0 || ok !== 1'b1) $display("FAIL reset_status: rdt=%h ack_ok=%b, want 00000000/1", r, ok);
    else n_pass++;
    wb_xfer(1'b0, 1'b0, r, ok);
    n_total++;
    if (r !== 32'h0 || ok !== 1'b1) $display("FAIL reset_data: rdt=%h ack_ok=%b, want 00000000/1", r, ok);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [31:0] r;
    logic ok;
    logic [31:0] exp [3] = '{32'h241, 32'h242, 32'h343};
    push(8'h41, 1'b0);
    push(8'h42, 1'b0);
    push(8'h43, 1'b1);
    wb_xfer(1'b1, 1'b0, r, ok);
    n_total++;
    if (r !== 32'h3) $display("FAIL basic_count3: got %h want 00000003", r);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      wb_xfer(1'b0, 1'b0, r, ok);
      n_total++;
      if (r !== exp[i] || ok !== 1'b1) $display("FAIL basic_data%0d: got %h ack_ok=%b want %h", i, r, ok, exp[i]);
      else n_pass++;
    end
    wb_xfer(1'b0, 1'b0, r, ok);
    n_total++;
    if (r !== 32'h0) $display("FAIL basic_empty_read: got %h want 00000000", r);
    else n_pass++;
    wb_xfer(1'b1, 1'b0, r, ok);
    n_total++;
    if (r !== 32'h0) $display("FAIL basic_count0: got %h want 00000000", r);
    else n_pass++;
  endtask

  task automatic test_full_wrap();
    logic [31:0] r;
    logic ok;
    int bad_rdy;
    bad_rdy = 0;
    for (int i = 0; i < 16; i++) begin
      tdata  = 8'(i);
      tvalid = 1'b1;
      if (tready !== 1'b1) bad_rdy++;
      step();
    end
    n_total++;
    if (bad_rdy != 0) $display("FAIL full_fill_ready: %0d cycles with tready low, want 0", bad_rdy);
    else n_pass++;
    n_total++;
    if (tready !== 1'b0) $display("FAIL full_tready: got %b want 0", tready);
    else n_pass++;
    // Beat offered while full must be dropped on the floor.
    tdata = 8'hEE;
    step();
    tvalid = 1'b0;
    wb_xfer(1'b1, 1'b0, r, ok);
    n_total++;
    if (r !== 32'h0001_0010) $display("FAIL full_status: got %h want 00010010", r);
    else n_pass++;
    wb_adr = 1'b0;
    wb_stb = 1'b1;
    step();
    n_total++;
    if (wb_ack !== 1'b1 || wb_rdt !== 32'h200) $display("FAIL full_pop: ack=%b rdt=%h want 1/00000200", wb_ack, wb_rdt);
    else n_pass++;
    n_total++;
    if (tready !== 1'b1) $display("FAIL full_tready_rise: got %b want 1", tready);
    else n_pass++;
    wb_stb = 1'b0;
    step();
    push(8'h10, 1'b0);
    wb_xfer(1'b1, 1'b0, r, ok);
    n_total++;
    if (r !== 32'h0001_0010) $display("FAIL wrap_status: got %h want 00010010", r);
    else n_pass++;
    for (int i = 1; i <= 16; i++) begin
      wb_xfer(1'b0, 1'b0, r, ok);
      n_total++;
      if (r !== (32'h200 | 32'(i))) $display("FAIL wrap_data%0d: got %h want %h", i, r, 32'h200 | 32'(i));
      else n_pass++;
    end
    wb_xfer(1'b1, 1'b0, r, ok);
    n_total++;
    if (r !== 32'h0) $display("FAIL wrap_drained: got %h want 00000000", r);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic ok;
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i), 1'b0);
    for (int k = 0; k < 8; k++) begin
      tdata  = 8'h88 + 8'(k);
      tlast  = (k == 7);
      tvalid = 1'b1;
      wb_adr = 1'b0;
      wb_stb = 1'b1;
      step();
      tvalid = 1'b0;
      tlast  = 1'b0;
      wb_stb = 1'b0;
      n_total++;
      if (wb_ack !== 1'b1 || wb_rdt !== (32'h200 | 32'(8'h80 + 8'(k))))
        $display("FAIL b2b_data%0d: ack=%b rdt=%h want 1/%h", k, wb_ack, wb_rdt, 32'h200 | 32'(8'h80 + 8'(k)));
      else n_pass++;
      step();
    end
    wb_xfer(1'b1, 1'b0, r, ok);
    n_total++;
    if (r !== 32'h8) $display("FAIL b2b_count: got %h want 00000008", r);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      wb_xfer(1'b0, 1'b0, r, ok);
      n_total++;
      if (r !== ((k == 7) ? 32'h38F : (32'h200 | 32'(8'h88 + 8'(k)))))
        $display("FAIL b2b_drain%0d: got %h", k, r);
      else n_pass++;
    end
  endtask

  task automatic test_empty_push_read();
    logic [31:0] r;
    logic ok;
    tdata  = 8'h55;
    tvalid = 1'b1;
    wb_adr = 1'b0;
    wb_stb = 1'b1;
    step();
    tvalid = 1'b0;
    wb_stb = 1'b0;
    n_total++;
    if (wb_ack !== 1'b1 || wb_rdt !== 32'h0) $display("FAIL epr_same_cycle: ack=%b rdt=%h want 1/00000000", wb_ack, wb_rdt);
    else n_pass++;
    step();
    wb_xfer(1'b0, 1'b0, r, ok);
    n_total++;
    if (r !== 32'h255) $display("FAIL epr_next: got %h want 00000255", r);
    else n_pass++;
  endtask

  task automatic test_writes();
    logic [31:0] r;
    logic ok;
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b1);
    wb_xfer(1'b0, 1'b1, r, ok);
    n_total++;
    if (r !== 32'h0 || ok !== 1'b1) $display("FAIL wr_data: rdt=%h ack_ok=%b want 00000000/1", r, ok);
    else n_pass++;
    wb_xfer(1'b1, 1'b1, r, ok);
    n_total++;
    if (r !== 32'h0 || ok !== 1'b1) $display("FAIL wr_status: rdt=%h ack_ok=%b want 00000000/1", r, ok);
    else n_pass++;
    wb_xfer(1'b1, 1'b0, r, ok);
    n_total++;
    if (r !== 32'h2) $display("FAIL wr_count: got %h want 00000002", r);
    else n_pass++;
    wb_xfer(1'b0, 1'b0, r, ok);
    n_total++;
    if (r !== 32'h2A1) $display("FAIL wr_after0: got %h want 000002a1", r);
    else n_pass++;
    wb_xfer(1'b0, 1'b0, r, ok);
    n_total++;
    if (r !== 32'h3A2) $display("FAIL wr_after1: got %h want 000003a2", r);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic ok;
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1'b0);
    tdata  = 8'h99;
    tvalid = 1'b1;
    wb_adr = 1'b0;
    wb_stb = 1'b1;
    step();
    n_total++;
    if (wb_ack !== 1'b1 || wb_rdt !== 32'h2C0) $display("FAIL rst_pre: ack=%b rdt=%h want 1/000002c0", wb_ack, wb_rdt);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (wb_ack !== 1'b0 || wb_rdt !== 32'h0 || tready !== 1'b0)
      $display("FAIL rst_mid: ack=%b rdt=%h tready=%b want 0/00000000/0", wb_ack, wb_rdt, tready);
    else n_pass++;
    step();
    tvalid = 1'b0;
    wb_stb = 1'b0;
    rst    = 1'b0;
    step();
    n_total++;
    if (tready !== 1'b1) $display("FAIL rst_release_tready: got %b want 1", tready);
    else n_pass++;
    wb_xfer(1'b1, 1'b0, r, ok);
    n_total++;
    if (r !== 32'h0) $display("FAIL rst_count: got %h want 00000000", r);
    else n_pass++;
    wb_xfer(1'b0, 1'b0, r, ok);
    n_total++;
    if (r !== 32'h0 || ok !== 1'b1) $display("FAIL rst_data: rdt=%h ack_ok=%b want 00000000/1", r, ok);
    else n_pass++;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_full_wrap();
    test_back_to_back();
    test_empty_push_read();
    test_writes();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
